// File: rtl/serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_adder: multi-bit adder summing BITS_PER_CYCLE bits per clock     |
// | through a registered inter-slice carry. Optional subtract mode is       |
// | enabled by defining SERIAL_ADDER_SUB_EN.                                |
// | Revision: 1.0                                                           |
// +--------------------------------------------------------------------------+
module serial_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int BPC   = (BITS_PER_CYCLE < 1) ? 1 : BITS_PER_CYCLE;
    localparam int N     = WIDTH / BPC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > WIDTH) begin : g_bad_range
            $error("serial_adder: BITS_PER_CYCLE must lie in 1..WIDTH");
        end else if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_divisor
            $error("serial_adder: WIDTH must be a multiple of BITS_PER_CYCLE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_last;
    logic               w_sub;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic [BPC:0]       w_slice;
    logic [WIDTH-1:0]   w_res_next;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_sub = Sub;
`else
    assign w_sub = 1'b0;
`endif

    assign w_last  = (r_cnt == CNT_W'(N - 1));
    assign w_slice = {1'b0, r_a[BPC-1:0]} + {1'b0, r_b[BPC-1:0]} + {{BPC{1'b0}}, r_carry};

    // Result fills from the MSB end so slice 0 lands in the LSBs after N shifts.
    always_comb begin
        w_res_next                  = r_res >> BPC;
        w_res_next[WIDTH-1 -: BPC]  = w_slice[BPC-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1: invert B once at capture, seed carry with 1.
            r_a     <= A;
            r_b     <= w_sub ? ~B : B;
            r_carry <= w_sub | Cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> BPC;
            r_b     <= r_b >> BPC;
            r_carry <= w_slice[BPC];
            r_res   <= w_res_next;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_slice[BPC];
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign Sum  = r_sum;
    assign Cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_adder: self-checking bench for serial_adder at BITS_PER_CYCLE |
// | of 1, 4 and 8 on an 8-bit datapath, against an arithmetic model.        |
// | Revision: 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_serial_adder;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       st   [NDUT];
    logic [7:0] ai   [NDUT];
    logic [7:0] bi   [NDUT];
    logic       ci   [NDUT];
    logic       sb   [NDUT];
    logic       busy_o [NDUT];
    logic       done_o [NDUT];
    logic [7:0] sum_o  [NDUT];
    logic       cout_o [NDUT];

    logic [7:0] exp_sum  [NDUT];
    logic       exp_cout [NDUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    genvar k;
    generate
        for (k = 0; k < NDUT; k++) begin : g_dut
            serial_adder #(
                .WIDTH          (8),
                .BITS_PER_CYCLE ((k == 0) ? 1 : ((k == 1) ? 4 : 8))
            ) u_dut (
                .clk   (clk),
                .rst_n (rst_n),
                .start (st[k]),
                .A     (ai[k]),
                .B     (bi[k]),
                .Cin   (ci[k]),
`ifdef SERIAL_ADDER_SUB_EN
                .Sub   (sb[k]),
`endif
                .busy  (busy_o[k]),
                .done  (done_o[k]),
                .Sum   (sum_o[k]),
                .Cout  (cout_o[k])
            );
        end
    endgenerate

    function automatic int slices_of(input int idx);
        int bpc;
        bpc = (idx == 0) ? 1 : ((idx == 1) ? 4 : 8);
        return 8 / bpc;
    endfunction

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic c, input logic s);
        int full;
        if (s) full = int'(a) + (255 - int'(b)) + 1;
        else   full = int'(a) + int'(b) + int'(c);
        return 9'(full);
    endfunction

    // Full operation with cycle-exact busy/done/hold checks.
    task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic s, input string name);
        int         n;
        logic [8:0] full;
        n    = slices_of(idx);
        full = model(a, b, c, s);
        @(posedge clk); #1;
        st[idx] = 1'b1; ai[idx] = a; bi[idx] = b; ci[idx] = c; sb[idx] = s;
        @(posedge clk); #1;
        st[idx] = 1'b0; ai[idx] = 8'($urandom); bi[idx] = 8'($urandom); ci[idx] = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (busy_o[idx] !== 1'b1 || done_o[idx] !== 1'b0 ||
                sum_o[idx] !== exp_sum[idx] || cout_o[idx] !== exp_cout[idx]) begin
                errors++;
                $display("FAIL %s dut%0d run cycle %0d: busy=%b done=%b sum=%h cout=%b, expected busy=1 done=0 sum=%h cout=%b",
                         name, idx, i, busy_o[idx], done_o[idx], sum_o[idx], cout_o[idx],
                         exp_sum[idx], exp_cout[idx]);
            end
            @(posedge clk); #1;
        end
        exp_sum[idx]  = full[7:0];
        exp_cout[idx] = full[8];
        checks++;
        if (busy_o[idx] !== 1'b0 || done_o[idx] !== 1'b1 ||
            sum_o[idx] !== exp_sum[idx] || cout_o[idx] !== exp_cout[idx]) begin
            errors++;
            $display("FAIL %s dut%0d done cycle: busy=%b done=%b sum=%h cout=%b, expected busy=0 done=1 sum=%h cout=%b",
                     name, idx, busy_o[idx], done_o[idx], sum_o[idx], cout_o[idx],
                     exp_sum[idx], exp_cout[idx]);
        end
        @(posedge clk); #1;
        checks++;
        if (done_o[idx] !== 1'b0 || busy_o[idx] !== 1'b0 || sum_o[idx] !== exp_sum[idx]) begin
            errors++;
            $display("FAIL %s dut%0d after done: busy=%b done=%b sum=%h, expected busy=0 done=0 sum=%h",
                     name, idx, busy_o[idx], done_o[idx], sum_o[idx], exp_sum[idx]);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < NDUT; i++) begin
            st[i] = 1'b1; ai[i] = 8'hFF; bi[i] = 8'hFF; ci[i] = 1'b1; sb[i] = 1'b0;
            exp_sum[i] = 8'h00; exp_cout[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (busy_o[i] !== 1'b0 || done_o[i] !== 1'b0 || sum_o[i] !== 8'h00 || cout_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: busy=%b done=%b sum=%h cout=%b, expected all zero",
                         i, busy_o[i], done_o[i], sum_o[i], cout_o[i]);
            end
            st[i] = 1'b0;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (busy_o[i] !== 1'b0 || done_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle dut%0d: busy=%b done=%b, expected 0 0", i, busy_o[i], done_o[i]);
            end
        end
    endtask

    task automatic test_directed;
        run_op(0, 8'h35, 8'h4A, 1'b0, 1'b0, "add_35_4a");
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, "wrap_ff_01");
        run_op(0, 8'hFF, 8'h00, 1'b1, 1'b0, "wrap_cin");
        run_op(1, 8'h9C, 8'h77, 1'b0, 1'b0, "bpc4_9c_77");
        run_op(2, 8'hC8, 8'h64, 1'b1, 1'b0, "bpc8_single_slice");
        run_op(2, 8'h00, 8'h00, 1'b0, 1'b0, "bpc8_zero");
    endtask

    // Start during RUN is ignored; start in the done cycle chains a new operation.
    task automatic test_back_to_back;
        @(posedge clk); #1;
        st[0] = 1'b1; ai[0] = 8'h01; bi[0] = 8'h02; ci[0] = 1'b0; sb[0] = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) begin
                st[0] = 1'b1; ai[0] = 8'hF0; bi[0] = 8'hF0;
            end else begin
                st[0] = 1'b0;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (done_o[0] !== 1'b1 || sum_o[0] !== 8'h03 || cout_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: done=%b sum=%h cout=%b, expected done=1 sum=03 cout=0",
                     done_o[0], sum_o[0], cout_o[0]);
        end
        st[0] = 1'b1; ai[0] = 8'h10; bi[0] = 8'h20; ci[0] = 1'b0;
        @(posedge clk); #1;
        st[0] = 1'b0;
        checks++;
        if (busy_o[0] !== 1'b1 || done_o[0] !== 1'b0 || sum_o[0] !== 8'h03) begin
            errors++;
            $display("FAIL chain_accept: busy=%b done=%b sum=%h, expected busy=1 done=0 sum=03",
                     busy_o[0], done_o[0], sum_o[0]);
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (done_o[0] !== 1'b1 || sum_o[0] !== 8'h30 || cout_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL chain_result: done=%b sum=%h cout=%b, expected done=1 sum=30 cout=0",
                     done_o[0], sum_o[0], cout_o[0]);
        end
        exp_sum[0] = 8'h30; exp_cout[0] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop;
        bit seen;
        @(posedge clk); #1;
        st[0] = 1'b1; ai[0] = 8'hAA; bi[0] = 8'h55; ci[0] = 1'b0; sb[0] = 1'b0;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_o[0] !== 1'b0 || done_o[0] !== 1'b0 || sum_o[0] !== 8'h00 || cout_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b sum=%h cout=%b, expected all zero",
                     busy_o[0], done_o[0], sum_o[0], cout_o[0]);
        end
        for (int i = 0; i < NDUT; i++) begin
            exp_sum[i] = 8'h00; exp_cout[i] = 1'b0;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL no_done_after_reset: activity seen=%b, expected 0", seen);
        end
        run_op(0, 8'h0F, 8'h01, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_sub;
`ifdef SERIAL_ADDER_SUB_EN
        run_op(0, 8'h10, 8'h20, 1'b1, 1'b1, "sub_borrow");
        run_op(0, 8'h20, 8'h10, 1'b0, 1'b1, "sub_no_borrow");
        run_op(0, 8'h20, 8'h10, 1'b0, 1'b0, "sub_off_add");
        run_op(1, 8'h05, 8'h05, 1'b1, 1'b1, "sub_equal_bpc4");
`endif
    endtask

    task automatic test_random;
        logic s;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < NDUT; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
                s = 1'($urandom);
`else
                s = 1'b0;
`endif
                run_op(i, 8'($urandom), 8'($urandom), 1'($urandom), s, "random");
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            st[i] = 1'b0; ai[i] = '0; bi[i] = '0; ci[i] = 1'b0; sb[i] = 1'b0;
        end
        test_reset;
        test_directed;
        test_back_to_back;
        test_reset_midop;
        test_sub;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised multi-bit adder that processes BITS_PER_CYCLE operand bits per clock, using a registered carry between slices.
It trades latency for area relative to a fully combinational ripple adder.
It is the sequential successor of the single-bit half/full adder cells and is used where wide sums are needed but gate count matters.
Control is start/busy/done; the result is held on the outputs until the next operation completes.

Parameters:
- WIDTH, 8, operand and sum width in bits.
- BITS_PER_CYCLE, 1, bits summed per clock. Must satisfy 1 <= BITS_PER_CYCLE <= WIDTH and WIDTH % BITS_PER_CYCLE == 0; elaboration error otherwise.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when idle or done.
- A  input  WIDTH  operand A, captured on accepted start.
- B  input  WIDTH  operand B, captured on accepted start.
- Cin  input  1  carry-in, captured on accepted start.
- busy  output  1  high while slices are being summed.
- done  output  1  one-cycle pulse; Sum/Cout valid from this cycle.
- Sum  output  WIDTH  registered result, held until the next completion.
- Cout  output  1  registered carry-out of the MSB.

Behaviour:
- N = WIDTH / BITS_PER_CYCLE slices. Slice i = bits [i*BPC +: BPC], processed LSB slice first.
- Reset (asynchronous, any time, including mid-operation):
  - state = IDLE; busy = 0, done = 0, Sum = 0, Cout = 0.
  - Operand shift registers, carry register and slice counter cleared; any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start = 1 -> capture A, B into shift registers, carry_reg = Cin, cnt = 0, go to RUN. Otherwise stay.
  - RUN (busy = 1): each edge computes {c, s} = a_slice + b_slice + carry_reg at (BPC+1)-bit width, with zero-extended operands.
    - Shift s into the MSB end of the internal result register; shift operands right by BPC; carry_reg = c; cnt++.
    - On the edge processing slice N-1: go to DONE, load the Sum output register from the result, load Cout = final carry.
  - DONE (done = 1, busy = 0): a single cycle.
    - start = 1 -> accept new operands exactly as in IDLE and go to RUN (back-to-back operation).
    - Otherwise go to IDLE.
- Timing: start sampled at edge 0.
  - busy is high for exactly N cycles, after edges 0..N-1.
  - done is high for one cycle after edge N; latency start -> done = N+1 cycles.
- start while in RUN is ignored; operands are not re-sampled.
- A, B and Cin may change freely after acceptance.
- Sum/Cout change only at completion (or reset); they are never partially updated.
- Result = (A + B + Cin) mod 2^WIDTH; Cout = bit WIDTH of the full sum.
- With BITS_PER_CYCLE = WIDTH: N = 1, busy lasts 1 cycle, done arrives 2 cycles after start.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port Sub (1 bit), captured on accepted start.
  - Sub = 1 computes A + ~B + 1; Cin is ignored and the carry register is seeded with 1.
  - Cout = 1 means no borrow (A >= B unsigned).
  - Sub = 0 behaves exactly as the base adder.
- Not defined: the Sub port is absent and the block always adds.
- Timing is identical in both builds.

Test Plan:
1. WIDTH=8, BPC=1: A=0x35, B=0x4A, Cin=0, start 1 cycle -> busy high 8 cycles; done pulses 9 cycles after start; Sum=0x7F, Cout=0.
2. A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1. Then A=0xFF, B=0x00, Cin=1 -> Sum=0x00, Cout=1.
3. Start with A=0x01, B=0x02; during RUN pulse start with A=0xF0, B=0xF0 -> ignored, done with Sum=0x03. Assert start in the done cycle with A=0x10, B=0x20 -> busy next cycle, second done gives Sum=0x30.
4. Start A=0xAA, B=0x55; drop rst_n after 4 busy cycles -> busy/done/Sum/Cout = 0 immediately, no done pulse. After release, A=0x0F, B=0x01 -> Sum=0x10.
5. WIDTH=8, BPC=4: A=0x9C, B=0x77, Cin=0 -> busy 2 cycles, done 3 cycles after start, Sum=0x13, Cout=1.
6. SERIAL_ADDER_SUB_EN defined, Sub=1:
   - A=0x10, B=0x20 -> Sum=0xF0, Cout=0.
   - A=0x20, B=0x10 -> Sum=0x10, Cout=1.
   - Sub=0, A=0x20, B=0x10 -> Sum=0x30.
